sys_ctrl_sched: RTL
===================

Name: sys_ctrl_sched

Overview:
- Command scheduler between the UART RX/TX path and the shared register file and ALU.
- Parses command frames of received bytes and issues register-file reads/writes and ALU operations.
- Gates the ALU clock via the clock-gate enable.
- Returns read data and ALU results to the UART TX through a valid/ready byte handshake.

Parameters:
- DATA_WIDTH, 8, width of UART bytes, register data and ALU operands.
- ADDR_WIDTH, 4, register-file address width.
- FUN_WIDTH, 4, ALU function code width.
- TIMEOUT_CYCLES, 1024, inter-byte timeout limit (used only with CMD_TIMEOUT_EN).

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset; synchronous, active-high.
- RX_P_DATA  in  DATA_WIDTH  received byte.
- RX_D_VLD  in  1  one-cycle strobe; RX_P_DATA valid.
- RdData  in  DATA_WIDTH  register-file read data.
- RdData_Valid  in  1  read data strobe.
- ALU_OUT  in  2*DATA_WIDTH  ALU result.
- OUT_Valid  in  1  ALU result strobe.
- TX_READY  in  1  TX can accept a byte.
- WrEn  out  1  register write strobe.
- RdEn  out  1  register read strobe.
- Address  out  ADDR_WIDTH  register address.
- WrData  out  DATA_WIDTH  register write data.
- ALU_EN  out  1  ALU start strobe.
- ALU_FUN  out  FUN_WIDTH  ALU function.
- CLK_EN  out  1  ALU clock-gate enable.
- TX_P_DATA  out  DATA_WIDTH  byte to transmit.
- TX_D_VLD  out  1  TX byte valid.
- CMD_ERR  out  1  one-cycle pulse on unknown command byte.

Behaviour:
- Reset: on a CLK edge with RST=1, state=IDLE and all outputs 0. RST high mid-frame aborts the frame; no strobe fires in the reset cycle.
- Outputs are registered; each strobe appears the cycle after the triggering input.
- Command bytes, accepted only in IDLE on RX_D_VLD:
  - 0xAA write: addr, data.
  - 0xBB read: addr.
  - 0xCC ALU with operands: A, B, fun.
  - 0xDD ALU without operands: fun.
- Any other byte in IDLE: one-cycle CMD_ERR pulse, stay in IDLE.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN, ALU_WAIT, TX_LO, TX_HI.
- WR_ADDR: latch RX_P_DATA[ADDR_WIDTH-1:0] into Address; go to WR_DATA.
- WR_DATA: on byte, pulse WrEn for 1 cycle with WrData=byte at the latched Address; go to IDLE.
- RD_ADDR: on byte, latch Address, pulse RdEn for 1 cycle; go to RD_WAIT.
- RD_WAIT: on RdData_Valid, latch RdData into TX_P_DATA, assert TX_D_VLD; go to TX_HI (single-byte send; TX_HI is reused as the final byte).
- OP_A: on byte, pulse WrEn to Address 0.
- OP_B: on byte, pulse WrEn to Address 1.
- ALU_FUN: on byte, latch ALU_FUN, pulse ALU_EN, set CLK_EN=1; go to ALU_WAIT.
- ALU_WAIT: CLK_EN stays 1. On OUT_Valid, latch ALU_OUT and drop CLK_EN next cycle; go to TX_LO.
- TX handshake: TX_D_VLD held with stable TX_P_DATA until a cycle with TX_D_VLD & TX_READY; the byte transfers in that cycle.
- TX_LO: sends ALU_OUT[7:0], then goes to TX_HI.
- TX_HI: sends ALU_OUT[15:8] (or the read byte); after transfer, TX_D_VLD=0 and go to IDLE.
- RX_D_VLD in RD_WAIT, ALU_WAIT, TX_LO or TX_HI: byte dropped, no state change, no CMD_ERR.
- Read/ALU strobes arriving in any other state are ignored.
- Response strobe arriving in the same cycle as RX_D_VLD: the response wins.
- Address width truncation: address bytes use the low ADDR_WIDTH bits only.

Optional Feature:
- Macro: CMD_TIMEOUT_EN.
- Defined: a counter runs in WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B and ALU_FUN, and clears on every RX_D_VLD.
  - On reaching TIMEOUT_CYCLES-1: go to IDLE and pulse CMD_ERR.
  - No strobes are issued for the partial frame.
  - Wait and TX states are not timed.
- Undefined: no counter; the FSM waits indefinitely for the next byte. TIMEOUT_CYCLES is unused.

Test Plan:
- Bytes AA,05,3C -> one WrEn pulse with Address=5, WrData=0x3C; back to IDLE; no TX.
- Bytes BB,07; RdData=0x9E with RdData_Valid two cycles after RdEn; TX_READY=1 -> exactly one RdEn (Address=7); one TX transfer of 0x9E.
- Bytes CC,12,34,01; OUT_Valid after 3 cycles with ALU_OUT=0xABCD; TX_READY held 0 for 5 cycles then 1:
  - WrEn to addr0=0x12, then addr1=0x34.
  - ALU_EN with ALU_FUN=1; CLK_EN high until OUT_Valid.
  - TX_P_DATA stable at 0xCD until transfer, then 0xAB.
- Byte 0x55 in IDLE -> CMD_ERR single pulse; then DD,02 -> ALU_EN with ALU_FUN=2 and no WrEn.
- RST=1 for one cycle after AA,05 -> no WrEn; next frame AA,03,11 writes 0x11 to addr 3.
- CMD_TIMEOUT_EN with TIMEOUT_CYCLES=16: byte BB then silence -> CMD_ERR 16 cycles after BB, no RdEn, state IDLE.

Source files
------------

// File: rtl/sys_ctrl_sched.sv
// sys_ctrl_sched: parses UART command frames into register-file and ALU operations
// and returns results over a valid/ready TX byte handshake. Optional macro: CMD_TIMEOUT_EN.
module sys_ctrl_sched #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int FUN_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]   RdData,
    input  logic                    RdData_Valid,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    OUT_Valid,
    input  logic                    TX_READY,
    output logic                    WrEn,
    output logic                    RdEn,
    output logic [ADDR_WIDTH-1:0]   Address,
    output logic [DATA_WIDTH-1:0]   WrData,
    output logic                    ALU_EN,
    output logic [FUN_WIDTH-1:0]    ALU_FUN,
    output logic                    CLK_EN,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD,
    output logic                    CMD_ERR
);
    // state      | meaning
    // S_IDLE     | waiting for a command byte
    // S_WR_ADDR  | write: waiting for address byte
    // S_WR_DATA  | write: waiting for data byte
    // S_RD_ADDR  | read: waiting for address byte
    // S_RD_WAIT  | read: waiting for register-file data
    // S_OP_A     | ALU: waiting for operand A (goes to reg 0)
    // S_OP_B     | ALU: waiting for operand B (goes to reg 1)
    // S_ALU_FUN  | ALU: waiting for function byte
    // S_ALU_WAIT | ALU running, clock gate open
    // S_TX_LO    | sending low result byte
    // S_TX_HI    | sending high result byte or the read byte
    typedef enum logic [3:0] {
        S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT,
        S_OP_A, S_OP_B, S_ALU_FUN, S_ALU_WAIT, S_TX_LO, S_TX_HI
    } state_t;

    localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_OPS = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_FUN = DATA_WIDTH'(8'hDD);

    state_t                  state, state_nxt;
    logic                    wr_en_nxt, rd_en_nxt, alu_en_nxt, cmd_err_nxt;
    logic                    clk_en_nxt, tx_vld_nxt;
    logic [ADDR_WIDTH-1:0]   addr_nxt;
    logic [DATA_WIDTH-1:0]   wr_data_nxt, tx_data_nxt, tx_hi_q, tx_hi_nxt;
    logic [FUN_WIDTH-1:0]    fun_nxt;
    logic                    timed, tmo_hit, tx_xfer;

    assign timed   = (state == S_WR_ADDR) || (state == S_WR_DATA) || (state == S_RD_ADDR) ||
                     (state == S_OP_A)    || (state == S_OP_B)    || (state == S_ALU_FUN);
    assign tx_xfer = TX_D_VLD && TX_READY;

`ifdef CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] tmo_cnt;

    // Loaded so it reaches zero on the cycle the silent count would reach TIMEOUT_CYCLES-1.
    always_ff @(posedge CLK) begin
        if (RST || !timed || RX_D_VLD)
            tmo_cnt <= TW'(TIMEOUT_CYCLES - 2);
        else if (tmo_cnt != '0)
            tmo_cnt <= tmo_cnt - TW'(1);
    end
    assign tmo_hit = timed && !RX_D_VLD && (tmo_cnt == '0);
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        wr_en_nxt   = 1'b0;
        rd_en_nxt   = 1'b0;
        alu_en_nxt  = 1'b0;
        cmd_err_nxt = 1'b0;
        addr_nxt    = Address;
        wr_data_nxt = WrData;
        fun_nxt     = ALU_FUN;
        clk_en_nxt  = CLK_EN;
        tx_data_nxt = TX_P_DATA;
        tx_vld_nxt  = TX_D_VLD;
        tx_hi_nxt   = tx_hi_q;
        case (state)
            S_IDLE: if (RX_D_VLD) begin
                case (RX_P_DATA)
                    CMD_WR:  state_nxt = S_WR_ADDR;
                    CMD_RD:  state_nxt = S_RD_ADDR;
                    CMD_OPS: state_nxt = S_OP_A;
                    CMD_FUN: state_nxt = S_ALU_FUN;
                    default: cmd_err_nxt = 1'b1;
                endcase
            end
            S_WR_ADDR: if (RX_D_VLD) begin
                addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
                state_nxt = S_WR_DATA;
            end
            S_WR_DATA: if (RX_D_VLD) begin
                wr_en_nxt   = 1'b1;
                wr_data_nxt = RX_P_DATA;
                state_nxt   = S_IDLE;
            end
            S_RD_ADDR: if (RX_D_VLD) begin
                addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
                rd_en_nxt = 1'b1;
                state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: if (RdData_Valid) begin
                tx_data_nxt = RdData;
                tx_vld_nxt  = 1'b1;
                state_nxt   = S_TX_HI;
            end
            S_OP_A: if (RX_D_VLD) begin
                wr_en_nxt   = 1'b1;
                addr_nxt    = ADDR_WIDTH'(0);
                wr_data_nxt = RX_P_DATA;
                state_nxt   = S_OP_B;
            end
            S_OP_B: if (RX_D_VLD) begin
                wr_en_nxt   = 1'b1;
                addr_nxt    = ADDR_WIDTH'(1);
                wr_data_nxt = RX_P_DATA;
                state_nxt   = S_ALU_FUN;
            end
            S_ALU_FUN: if (RX_D_VLD) begin
                fun_nxt    = RX_P_DATA[FUN_WIDTH-1:0];
                alu_en_nxt = 1'b1;
                clk_en_nxt = 1'b1;
                state_nxt  = S_ALU_WAIT;
            end
            S_ALU_WAIT: if (OUT_Valid) begin
                tx_data_nxt = ALU_OUT[DATA_WIDTH-1:0];
                tx_hi_nxt   = ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
                tx_vld_nxt  = 1'b1;
                clk_en_nxt  = 1'b0;
                state_nxt   = S_TX_LO;
            end
            S_TX_LO: if (tx_xfer) begin
                tx_data_nxt = tx_hi_q;
                state_nxt   = S_TX_HI;
            end
            S_TX_HI: if (tx_xfer) begin
                tx_vld_nxt = 1'b0;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // A stalled frame is abandoned without issuing anything.
        if (tmo_hit) begin
            state_nxt   = S_IDLE;
            cmd_err_nxt = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            WrEn      <= 1'b0;
            RdEn      <= 1'b0;
            Address   <= '0;
            WrData    <= '0;
            ALU_EN    <= 1'b0;
            ALU_FUN   <= '0;
            CLK_EN    <= 1'b0;
            TX_P_DATA <= '0;
            TX_D_VLD  <= 1'b0;
            CMD_ERR   <= 1'b0;
            tx_hi_q   <= '0;
        end else begin
            state     <= state_nxt;
            WrEn      <= wr_en_nxt;
            RdEn      <= rd_en_nxt;
            Address   <= addr_nxt;
            WrData    <= wr_data_nxt;
            ALU_EN    <= alu_en_nxt;
            ALU_FUN   <= fun_nxt;
            CLK_EN    <= clk_en_nxt;
            TX_P_DATA <= tx_data_nxt;
            TX_D_VLD  <= tx_vld_nxt;
            CMD_ERR   <= cmd_err_nxt;
            tx_hi_q   <= tx_hi_nxt;
        end
    end
endmodule
